// File: rtl/dm_sram_resp.sv
// dm_sram_resp: data-side SRAM-like responder for the MEM stage.
// One request per handshake; byte-lane stores and raw word loads against an
// internal 2^ADDR_W x 32-bit array. The response is a one-cycle data_ok strobe
// LATENCY cycles after the acceptance edge. A new request may be accepted in
// the response cycle, so back-to-back transactions have no bubble.

module dm_sram_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte-lane strobe for a store of the given size at the given byte offset.
    function automatic logic [3:0] lane_strobe(input logic [1:0] sz, input logic [1:0] ofs);
        logic [3:0] strb;
        case (sz)
            2'd0:    strb = 4'b0001 << ofs;
            2'd1:    strb = ofs[1] ? 4'b1100 : 4'b0011;
            2'd2:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    // Alignment / size error: misaligned half or word, or the reserved size code.
    function automatic logic align_err(input logic [1:0] sz, input logic [1:0] ofs);
        logic bad;
        case (sz)
            2'd0:    bad = 1'b0;
            2'd1:    bad = ofs[0];
            2'd2:    bad = (ofs != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // State and response registers
    state_t              r_state;
    logic [2:0]          r_cnt;
    logic                r_data_ok;
    logic                r_err;
    logic                r_err_pend;
    logic [31:0]         r_rdata;
    logic [31:0]         r_mem [DEPTH];

    // Request decode
    logic                w_addr_ok;
    logic                w_accept;
    logic                w_err;
    logic [3:0]          w_strb;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_wr_en;
    logic                w_rd_en;
    logic                w_busy;
    logic                w_unused;

    // Upper address bits alias onto the array and are deliberately ignored.
    assign w_unused  = ^addr[31:ADDR_W+2];

    // Acceptance is only possible out of reset, when idle or while responding.
    assign w_addr_ok = rst && ((r_state == ST_IDLE) || (r_state == ST_RESP));
    assign w_accept  = req && w_addr_ok;
    assign w_err     = align_err(size, addr[1:0]);
    assign w_strb    = lane_strobe(size, addr[1:0]);
    assign w_idx     = addr[ADDR_W+1:2];
    assign w_wr_en   = w_accept && wr && !w_err;
    assign w_rd_en   = w_accept && !wr && !w_err;

    // Busy while waiting, and while responding unless the next request is taken.
    assign w_busy    = (r_state == ST_WAIT) || ((r_state == ST_RESP) && !w_accept);

    assign addr_ok   = w_addr_ok;
    assign busy      = w_busy;
    assign data_ok   = r_data_ok;
    assign err       = r_err;
    assign rdata     = r_rdata;

    // Control FSM: latency counter, response strobe and error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_data_ok  <= 1'b0;
            r_err      <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            // data_ok and err are single-cycle; they are re-asserted below only
            // on the edge entering RESP.
            r_data_ok <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_accept) begin
                        if (LATENCY == 1) begin
                            r_state   <= ST_RESP;
                            r_data_ok <= 1'b1;
                            r_err     <= w_err;
                        end else begin
                            r_state    <= ST_WAIT;
                            r_cnt      <= 3'(LATENCY - 1);
                            r_err_pend <= w_err;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 3'd1) begin
                        r_state   <= ST_RESP;
                        r_cnt     <= 3'd0;
                        r_data_ok <= 1'b1;
                        r_err     <= r_err_pend;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

    // Load data capture at the acceptance edge; held until the next good load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 32'd0;
        end else if (w_rd_en) begin
            r_rdata <= r_mem[w_idx];
        end
    end

    // Store path: strobed byte lanes written at the acceptance edge (no reset).
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/dm_sram_resp.md
Name: dm_sram_resp

Overview:
- Data-side SRAM-like responder that serves the load/store requests issued by the core's MEM stage.
- Accepts one request per handshake and performs byte-lane writes or word reads against an internal word array.
- Returns a one-cycle data_ok response after a programmable latency.
- Used as the data memory behind the pipeline in simulation and FPGA builds, and as the reference timing model for the data port.

Parameters:
- ADDR_W, 10, word-address bits; array holds 2^ADDR_W 32-bit words.
- LATENCY, 1, cycles from acceptance edge to data_ok; legal range 1..7.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- req  input  1  request valid from the MEM stage
- wr  input  1  1 = store, 0 = load; sampled with req
- size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
- addr  input  32  byte address; bits [ADDR_W+1:2] index the array, upper bits ignored
- wdata  input  32  store data, already lane-aligned by the initiator
- addr_ok  output  1  request accepted this cycle when req is also high
- data_ok  output  1  one-cycle response strobe
- rdata  output  32  load data (raw word, no extension); valid when data_ok is high
- err  output  1  alignment/size error flag; valid when data_ok is high
- busy  output  1  a request is accepted but not yet responded

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, counter = 0.
  - data_ok = 0, err = 0, rdata = 0, busy = 0.
  - addr_ok is forced to 0 while rst is low.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - addr_ok = rst && (state == IDLE || state == RESP).
  - Accept = req && addr_ok, evaluated at a rising edge.
- On accept:
  - If LATENCY == 1, go to RESP; otherwise counter <= LATENCY-1 and go to WAIT.
  - WAIT: counter decrements each cycle. When counter == 1, next state is RESP.
  - RESP: data_ok = 1 for exactly that cycle. The next state is IDLE, or the accept path if a new request is accepted in RESP (back-to-back, no bubble).
- Effective latency: data_ok is high in the LATENCY-th cycle after the acceptance edge.
- busy = 1 in WAIT, and in RESP when no new request is accepted.
- Lane decode for stores:
  - byte: strobe = 1 << addr[1:0].
  - half: strobe = addr[1] ? 4'b1100 : 4'b0011.
  - word: strobe = 4'b1111.
  - Only strobed bytes of the word are written from the same lanes of wdata.
- Alignment errors: half with addr[0] = 1, word with addr[1:0] != 0, or size == 3.
  - The request is still accepted and responded with err = 1.
  - No array write occurs; rdata keeps its previous value.
- Load (no error): the array word is captured into the rdata register at the acceptance edge, so a load sees every store accepted at an earlier edge.
  - rdata holds until the next successful load response.
- Store: the array is written at the acceptance edge. data_ok is still returned after LATENCY; rdata is unchanged.
- err:
  - Registered with the response.
  - Low whenever data_ok is low.
- Address wrap: word index uses only addr[ADDR_W+1:2]; addresses alias modulo 2^(ADDR_W+2) bytes.
- req while not addr_ok (WAIT state): ignored. The initiator must hold req; no queuing is performed.
- Reset mid-operation:
  - The pending response is discarded; data_ok and busy drop immediately.
  - A store already accepted remains in the array.
  - After rst rises, the first edge with req high is accepted normally.

Test Plan:
- LATENCY = 1: word store 0xDEADBEEF at 0x40, then word load 0x40 back-to-back from RESP -> data_ok one cycle after each accept; load rdata = 0xDEADBEEF, err = 0; no idle cycle between responses.
- Byte stores 0x11, 0x22, 0x33, 0x44 to 0x80..0x83 (lanes from wdata), then word load 0x80 -> rdata = 0x44332211.
- Half store 0xAAAA at 0x102 over word 0x00000000, then load 0x100 -> rdata = 0xAAAA0000. Half store at 0x101 -> err = 1 with data_ok, word unchanged.
- LATENCY = 4: load accepted at edge E -> addr_ok = 0 and busy = 1 for 3 cycles; data_ok high only in the 4th cycle; req held during WAIT is not accepted until RESP.
- Wrap: with ADDR_W = 10, store 0x12345678 at 0x1000, load 0x0000 -> rdata = 0x12345678.
- Assert rst low in WAIT after store accept -> data_ok, busy, err = 0 immediately and addr_ok = 0 while low. After release, load of that address returns the stored data.
